// File: rtl/incdec_pkg.sv
// Shared definitions for the arbitrated up/down counter: opcodes, FSM states
// and a constant-evaluable clog2 helper.
package incdec_pkg;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/incdec_arbiter_rr.sv
// Combinational round-robin picker: first asserted req at or above ptr,
// wrapping modulo NREQ. Returns one-hot grant and its binary index.
module rr_arbiter
   import incdec_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx
);

   logic [IW-1:0]   cand [NREQ];
   logic [NREQ-1:0] rot_req;
   logic            found;

   // cand[gi] is the requester searched at priority position gi
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [IW:0] sum;
      assign sum         = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi]    = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
      assign rot_req[gi] = req[cand[gi]];
   end

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rot_req[k]) begin
            found = 1'b1;
            idx   = cand[k];
         end
      end
      if (found) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/incdec_arbiter.sv
// Up/down counter shared by NREQ requesters through a round-robin arbiter with
// bounded lock bursts. Define INCDEC_ARB_SATURATE_EN for saturating arithmetic.
module incdec_arbiter
   import incdec_pkg::*;
#(
   parameter  int WIDTH     = 4,
   parameter  int NREQ      = 4,
   parameter  int LOCK_MAX  = 8,
   parameter  int RESET_VAL = 1 << (WIDTH-2),
   localparam int OW        = clog2(NREQ)
) (
   input  logic                  i_clk,
   input  logic                  i_nReset,
   input  logic [NREQ-1:0]       i_req,
   input  logic [2*NREQ-1:0]     i_op,
   input  logic [WIDTH*NREQ-1:0] i_data,
   input  logic [NREQ-1:0]       i_lock,
   output logic [NREQ-1:0]       o_gnt,
   output logic [WIDTH-1:0]      o_count,
   output logic [OW-1:0]         o_owner,
   output logic                  o_locked,
   output logic                  o_wrap
);

   localparam int                BW       = clog2(LOCK_MAX + 1);
   localparam logic [BW-1:0]     LOCK_LIM = BW'(LOCK_MAX);
   localparam logic [WIDTH-1:0]  CNT_MAX  = '1;

   state_e           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [OW-1:0]    owner_reg, owner_next;
   logic [OW-1:0]    ptr_reg, ptr_next;
   logic [BW-1:0]    burst_reg, burst_next;
   logic             wrap_reg, wrap_next;

   logic [1:0]       op_arr   [NREQ];
   logic [WIDTH-1:0] data_arr [NREQ];
   logic [NREQ-1:0]  arb_gnt, gnt;
   logic [OW-1:0]    arb_idx, gnt_idx;
   logic             gnt_any;
   logic [BW-1:0]    burst_after;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_arr[gi]   = i_op[2*gi +: 2];
      assign data_arr[gi] = i_data[WIDTH*gi +: WIDTH];
   end

   function automatic logic [OW-1:0] ptr_inc(input logic [OW-1:0] i);
      return (i == OW'(NREQ-1)) ? '0 : i + 1'b1;
   endfunction

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req (i_req),
      .ptr (ptr_reg),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // A locked owner is the only candidate; everyone else waits
   always_comb begin
      gnt     = '0;
      gnt_idx = arb_idx;
      if (state_reg == ST_ARB) begin
         gnt = arb_gnt;
      end else begin
         gnt_idx = owner_reg;
         if (i_req[owner_reg]) gnt[owner_reg] = 1'b1;
      end
      if (!i_nReset) gnt = '0;
   end

   assign gnt_any     = |gnt;
   assign burst_after = (state_reg == ST_ARB) ? BW'(1) : burst_reg + 1'b1;

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      owner_next = owner_reg;
      ptr_next   = ptr_reg;
      burst_next = burst_reg;
      wrap_next  = 1'b0;
      if (gnt_any) begin
         owner_next = gnt_idx;
         ptr_next   = ptr_inc(gnt_idx);
         case (op_arr[gnt_idx])
            OP_INC: begin
`ifdef INCDEC_ARB_SATURATE_EN
               if (count_reg == CNT_MAX) wrap_next = 1'b1;
               else                      count_next = count_reg + 1'b1;
`else
               count_next = count_reg + 1'b1;
               wrap_next  = (count_reg == CNT_MAX);
`endif
            end
            OP_DEC: begin
`ifdef INCDEC_ARB_SATURATE_EN
               if (count_reg == '0) wrap_next = 1'b1;
               else                 count_next = count_reg - 1'b1;
`else
               count_next = count_reg - 1'b1;
               wrap_next  = (count_reg == '0);
`endif
            end
            OP_LOAD: count_next = data_arr[gnt_idx];
            default: ;
         endcase
         // The grant that brings the burst to LOCK_MAX always releases
         if (i_lock[gnt_idx] && (burst_after < LOCK_LIM)) begin
            state_next = ST_LOCKED;
            burst_next = burst_after;
         end else begin
            state_next = ST_ARB;
            burst_next = '0;
         end
      end else if ((state_reg == ST_LOCKED) && !i_req[owner_reg]) begin
         state_next = ST_ARB;
         burst_next = '0;
         ptr_next   = ptr_inc(owner_reg);
      end
   end

   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         state_reg <= ST_ARB;
         count_reg <= WIDTH'(RESET_VAL);
         owner_reg <= '0;
         ptr_reg   <= '0;
         burst_reg <= '0;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         owner_reg <= owner_next;
         ptr_reg   <= ptr_next;
         burst_reg <= burst_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign o_gnt    = gnt;
   assign o_count  = count_reg;
   assign o_owner  = owner_reg;
   assign o_locked = (state_reg == ST_LOCKED);
   assign o_wrap   = wrap_reg;

endmodule

// File: tb/tb_incdec_arbiter.sv
// Directed scoreboard bench for incdec_arbiter (default parameters); honours
// INCDEC_ARB_SATURATE_EN when computing expected wrap/saturate results.
module tb_incdec_arbiter;
   import incdec_pkg::*;

`ifdef INCDEC_ARB_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        i_clk;
   logic        i_nReset;
   logic [3:0]  i_req;
   logic [7:0]  i_op;
   logic [15:0] i_data;
   logic [3:0]  i_lock;
   logic [3:0]  o_gnt;
   logic [3:0]  o_count;
   logic [1:0]  o_owner;
   logic        o_locked;
   logic        o_wrap;

   typedef struct {
      int g;
      int cnt;
      bit wrap;
      bit lk;
   } exp_t;

   exp_t exp_q[$];
   exp_t pend_e;
   bit   pend;
   int   total;
   int   bad;

   incdec_arbiter dut (
      .i_clk    (i_clk),
      .i_nReset (i_nReset),
      .i_req    (i_req),
      .i_op     (i_op),
      .i_data   (i_data),
      .i_lock   (i_lock),
      .o_gnt    (o_gnt),
      .o_count  (o_count),
      .o_owner  (o_owner),
      .o_locked (o_locked),
      .o_wrap   (o_wrap)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input int r, input bit rq, input logic [1:0] op,
                        input logic [3:0] d, input bit lk);
      i_req[r]        = rq;
      i_op[2*r +: 2]  = op;
      i_data[4*r +: 4] = d;
      i_lock[r]       = lk;
   endtask

   task automatic push_exp(input int g, input int cnt, input bit w, input bit lk);
      exp_t e;
      e.g = g; e.cnt = cnt; e.wrap = w; e.lk = lk;
      exp_q.push_back(e);
   endtask

   // Monitor: grant seen at negedge pops an expectation; its result is checked
   // at the following negedge, after the accepting edge.
   initial begin
      pend = 1'b0;
      forever begin
         @(negedge i_clk);
         if (!i_nReset) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               chk("count",  32'(o_count),  32'(pend_e.cnt));
               chk("wrap",   32'(o_wrap),   32'(pend_e.wrap));
               chk("locked", 32'(o_locked), 32'(pend_e.lk));
               chk("owner",  32'(o_owner),  32'(pend_e.g));
               $display("txn gnt=%0d count=%0d wrap=%0d locked=%0d", pend_e.g, o_count, o_wrap, o_locked);
               pend = 1'b0;
            end
            if (o_gnt != '0) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_grant: got gnt=%b expected none", o_gnt);
               end else begin
                  pend_e = exp_q.pop_front();
                  chk("gnt", 32'(o_gnt), 32'(1) << pend_e.g);
                  pend = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad   = 0;
      i_nReset = 1'b0;
      i_req = '0; i_op = '0; i_data = '0; i_lock = '0;

      // Reset: grant suppressed even with a pending request
      drive(0, 1, OP_INC, 0, 0);
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_gnt",    32'(o_gnt),    0);
      chk("rst_count",  32'(o_count),  4);
      chk("rst_locked", 32'(o_locked), 0);
      chk("rst_wrap",   32'(o_wrap),   0);
      chk("rst_owner",  32'(o_owner),  0);
      i_nReset = 1'b1;
      push_exp(0, 5, 0, 0);
      step();
      drive(0, 0, OP_NOP, 0, 0);

      // Fairness: everyone INCs, pointer starts at 1
      step();
      for (int r = 0; r < 4; r++) drive(r, 1, OP_INC, 0, 0);
      push_exp(1, 6, 0, 0);
      push_exp(2, 7, 0, 0);
      push_exp(3, 8, 0, 0);
      push_exp(0, 9, 0, 0);
      push_exp(1, 10, 0, 0);
      repeat (5) step();
      for (int r = 0; r < 4; r++) drive(r, 0, OP_NOP, 0, 0);

      // Wrap / saturate
      drive(3, 1, OP_LOAD, 15, 0); push_exp(3, 15, 0, 0);            step();
      drive(3, 1, OP_INC, 0, 0);   push_exp(3, SAT ? 15 : 0, 1, 0);  step();
      drive(3, 1, OP_LOAD, 0, 0);  push_exp(3, 0, 0, 0);             step();
      drive(3, 1, OP_DEC, 0, 0);   push_exp(3, SAT ? 0 : 15, 1, 0);  step();
      drive(3, 1, OP_NOP, 0, 0);   push_exp(3, SAT ? 0 : 15, 0, 0);  step();
      drive(3, 0, OP_NOP, 0, 0);

      // Lock burst: req2 locks for LOCK_MAX grants, then req0, req1
      drive(1, 1, OP_LOAD, 1, 0); push_exp(1, 1, 0, 0); step();
      drive(0, 1, OP_INC, 0, 0);
      drive(1, 1, OP_INC, 0, 0);
      drive(2, 1, OP_INC, 0, 1);
      for (int i = 1; i <= 8; i++) push_exp(2, 1 + i, 0, i < 8);
      push_exp(0, 10, 0, 0);
      push_exp(1, 11, 0, 0);
      repeat (9) step();
      drive(0, 0, OP_NOP, 0, 0);
      drive(2, 0, OP_NOP, 0, 0);
      step();
      drive(1, 0, OP_NOP, 0, 0);

      // Lock abandon
      drive(1, 1, OP_INC, 0, 1); push_exp(1, 12, 0, 1); step();
      drive(1, 0, OP_NOP, 0, 0);
      drive(2, 1, OP_INC, 0, 0);
      push_exp(2, 13, 0, 0);
      #1;
      chk("abandon_gnt",    32'(o_gnt),    0);
      chk("abandon_locked", 32'(o_locked), 1);
      step();
      chk("abandon_unlock", 32'(o_locked), 0);
      chk("abandon_count",  32'(o_count),  12);
      step();
      drive(2, 0, OP_NOP, 0, 0);

      // Final (LOCK_MAX-th) grant carries LOAD 9 with lock still set
      drive(3, 1, OP_LOAD, 0, 1); push_exp(3, 0, 0, 1); step();
      drive(3, 1, OP_INC, 0, 1);
      for (int i = 1; i <= 6; i++) push_exp(3, i, 0, 1);
      repeat (6) step();
      drive(3, 1, OP_LOAD, 9, 1); push_exp(3, 9, 0, 0); step();
      drive(3, 0, OP_NOP, 0, 0);

      // Reset asserted mid-burst
      drive(0, 1, OP_INC, 0, 1);
      push_exp(0, 10, 0, 1);
      push_exp(0, 11, 0, 1);
      push_exp(0, 12, 0, 1);
      step();
      step();
      #5;
      i_nReset = 1'b0;
      #1;
      chk("midrst_gnt",    32'(o_gnt),    0);
      chk("midrst_count",  32'(o_count),  4);
      chk("midrst_locked", 32'(o_locked), 0);
      chk("midrst_wrap",   32'(o_wrap),   0);
      step();
      step();
      drive(0, 1, OP_INC, 0, 0);
      i_nReset = 1'b1;
      push_exp(0, 5, 0, 0);
      step();
      drive(0, 0, OP_NOP, 0, 0);

      repeat (3) step();
      chk("queue_empty", 32'(exp_q.size()), 0);
      chk("no_pending",  32'(pend), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/incdec_arbiter.md
Name: incdec_arbiter

Overview:
- Shares one up/down counter resource between NREQ requesters.
- Each requester issues INC/DEC/LOAD/NOP commands. A round-robin arbiter picks one command per cycle and applies it to the registered counter.
- A requester may lock the counter for a bounded burst of consecutive commands.
- Sits between control agents and the counter that feeds the datapath; exports the count, the current owner and boundary events.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- NREQ, 4, number of requesters (2..8).
- LOCK_MAX, 8, max consecutive grants to a locked owner before forced release (>= 1).
- RESET_VAL, 1 << (WIDTH-2), counter value after reset.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_nReset  in  1  asynchronous active-low reset.
- i_req  in  NREQ  per-requester command valid.
- i_op  in  2*NREQ  per-requester opcode, requester n at [2n+1:2n]; 00 NOP, 01 INC, 10 DEC, 11 LOAD.
- i_data  in  WIDTH*NREQ  per-requester load value, requester n at [WIDTH*n +: WIDTH].
- i_lock  in  NREQ  per-requester lock request, sampled only when that requester is granted.
- o_gnt  out  NREQ  one-hot combinational grant; command accepted on the edge ending a cycle with gnt high.
- o_count  out  WIDTH  registered counter value.
- o_owner  out  clog2(NREQ)  index of last granted requester (registered).
- o_locked  out  1  high while in LOCKED state.
- o_wrap  out  1  one-cycle registered pulse on boundary event.

Behaviour:
- Reset, asynchronous, any cycle, including mid-burst:
  - o_count = RESET_VAL, o_owner = 0, o_locked = 0, o_wrap = 0.
  - State ARB, rr pointer = 0, burst counter = 0.
  - o_gnt is 0 while i_nReset is low.
- Grant logic (combinational from registered state):
  - ARB: the first i_req bit found searching from rr pointer upward, modulo NREQ.
  - LOCKED: gnt = i_req[owner] only; other requesters wait.
  - No req is pending -> o_gnt = 0 and nothing changes.
- Handshake:
  - A requester holds i_req, i_op, i_data and i_lock stable until it sees its o_gnt high.
  - It may present the next command in the following cycle.
  - Back-to-back grants to the same requester are legal.
- Command effect on the edge of the grant cycle (latency 1):
  - INC: count+1.
  - DEC: count-1.
  - LOAD: i_data slice.
  - NOP: count unchanged but still consumes the grant and lock accounting.
- Arithmetic is modulo 2^WIDTH.
  - o_wrap = 1 for the next cycle when INC takes max -> 0 or DEC takes 0 -> max.
  - LOAD never sets o_wrap.
- rr pointer update: after any grant in ARB, pointer = granted index + 1 (mod NREQ).
- FSM:
  - ARB -> LOCKED: the granted requester has i_lock = 1. Then owner = index and burst counter = 1.
  - LOCKED -> LOCKED: owner granted with i_lock = 1 and burst counter < LOCK_MAX. Burst counter increments.
  - LOCKED -> ARB, any of:
    - owner granted with i_lock = 0;
    - owner granted while burst counter == LOCK_MAX (forced release);
    - owner's i_req is low for a cycle (abandon, no command applied).
  - On any exit, rr pointer = owner + 1, so the owner gets lowest priority next round.
  - LOCK_MAX = 1: a lock never extends past its first grant.
- Simultaneous events:
  - Forced release and i_lock = 1 on the same grant: the command is applied and the state still returns to ARB.
  - An out-of-range value on the unused encoding space is impossible; all 4 opcodes are defined.

Optional Feature:
- Macro INCDEC_ARB_SATURATE_EN.
- Defined:
  - INC at max holds max; DEC at 0 holds 0.
  - o_wrap instead pulses on a saturated (blocked) step.
  - LOAD is unaffected.
- Undefined: modulo wrap as above.

Decomposition:
- Package incdec_pkg:
  - opcode constants OP_NOP/OP_INC/OP_DEC/OP_LOAD;
  - FSM state encoding ST_ARB/ST_LOCKED;
  - a clog2 helper function.
- One sub-module rr_arbiter (NREQ):
  - inputs req vector and pointer;
  - output one-hot grant plus binary index;
  - purely combinational.
- FSM, burst counter and datapath stay in incdec_arbiter.

Test Plan:
- Reset: WIDTH=4, hold i_nReset low mid-burst -> o_count=4, o_locked=0, o_gnt=0; after release, first INC from req0 -> o_count=5 next cycle.
- Fairness: all 4 requesters hold INC continuously -> o_gnt sequence 0,1,2,3,0 one per cycle; o_count rises by 1 each cycle.
- Wrap: LOAD 15 then INC -> o_count=0, o_wrap pulse 1 cycle; LOAD 0 then DEC -> 15, o_wrap pulse. With INCDEC_ARB_SATURATE_EN: 15 stays 15 and 0 stays 0, each with an o_wrap pulse.
- Lock burst: req2 INC with i_lock=1 while req0/req1 request, LOCK_MAX=8 -> 8 consecutive gnt to 2, o_locked high; forced release; next grant goes to req3 if requesting, else req0.
- Lock abandon: req1 locks, then drops i_req for one cycle -> o_locked falls, req2 is granted the following cycle, count is not changed by the abandon cycle.
- Simultaneous: owner's final (LOCK_MAX-th) grant carries LOAD 9 with i_lock=1 -> o_count=9, state returns to ARB, o_locked=0.
